// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, types and register indices for the integer register file
//
// Purpose: default widths, register index/data types and the architectural
//          register numbers that the register file and its users refer to.
// Ports:   none (package).

package regfile_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH    = 32;

    typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0]    reg_data_t;

    // x0 is hardwired to zero; a0 is the ABI return/argument register
    localparam int REG_ZERO = 0;
    localparam int REG_A0   = 10;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write scoreboard with claim/release and issue readiness
//
// Purpose: one pending bit per architectural register. Decode claims a
//          destination at issue and writeback releases it. A claim and a
//          release of the same register on the same edge leaves it pending,
//          because the new producer now owns it.
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset, clears every pending bit
//   iss_valid  decode wants to claim iss_rd
//   iss_rd     destination being claimed
//   rel_valid  writeback is releasing rel_rd this cycle (already excludes x0)
//   rel_rd     register being released
//   pending    current pending bit-vector, bit 0 is always 0
//   iss_ready  claim of iss_rd can be accepted this cycle

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]    iss_rd,
    input  logic                        rel_valid,
    input  logic [ADDRESS_WIDTH-1:0]    rel_rd,
    output logic [2**ADDRESS_WIDTH-1:0] pending,
    output logic                        iss_ready
);

    localparam int DEPTH = 2**ADDRESS_WIDTH;

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic             iss_is_zero;
    logic             claim;

    assign iss_is_zero = (iss_rd == ADDRESS_WIDTH'(REG_ZERO));

    // A still-pending destination may be reclaimed only when it is being
    // released on this very edge.
    assign iss_ready = ~pending_q[iss_rd] | iss_is_zero |
                       (rel_valid & (rel_rd == iss_rd));

    assign claim = iss_valid & iss_ready & ~iss_is_zero;

    // Clear first, then set: set wins for a simultaneous claim and release.
    always_comb begin
        pending_d = pending_q;
        if (rel_valid) begin
            pending_d[rel_rd] = 1'b0;
        end
        if (claim) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with pending-write scoreboard and a0 debug tap
//
// Purpose: NUM_READ combinational read ports, one synchronous write port,
//          x0 hardwired to zero, per-register pending-write scoreboard and a
//          debug mirror of register DBG_REG.
// Build option: define REGFILE_BYPASS_EN for write-through forwarding of the
//          write port onto matching read ports (data and busy) in the same
//          cycle. Without it, reads show stored state only.
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   ad_rd      packed read addresses, port i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   rd_data    packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_busy    port i source register has a pending write
//   we3        write enable
//   ad3        write address (also the scoreboard release index)
//   wd3        write data
//   iss_valid  decode requests to claim iss_rd
//   iss_rd     destination being claimed
//   iss_ready  claim can be accepted this cycle
//   a0         stored contents of register DBG_REG (never bypassed)

module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int NUM_READ      = 2,
    parameter int DBG_REG       = REG_A0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  ad_rd,
    output logic [NUM_READ*DATA_WIDTH-1:0]     rd_data,
    output logic [NUM_READ-1:0]                rd_busy,
    input  logic                               we3,
    input  logic [ADDRESS_WIDTH-1:0]           ad3,
    input  logic [DATA_WIDTH-1:0]              wd3,
    input  logic                               iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]           iss_rd,
    output logic                               iss_ready,
    output logic [DATA_WIDTH-1:0]              a0
);

    localparam int                     DEPTH   = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX = ADDRESS_WIDTH'(DBG_REG);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic                  wr_en;

    // Writes to x0 are dropped, so they neither store nor release anything.
    assign wr_en = we3 & (ad3 != ADDRESS_WIDTH'(REG_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en) begin
            mem[ad3] <= wd3;
        end
    end

    regfile_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rel_valid (wr_en),
        .rel_rd    (ad3),
        .pending   (pending),
        .iss_ready (iss_ready)
    );

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] addr;
        logic                     is_zero;

        assign addr    = ad_rd[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign is_zero = (addr == ADDRESS_WIDTH'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
        // wr_en already excludes x0, so a hit never targets the zero register.
        logic hit;
        assign hit = wr_en & (ad3 == addr);

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = is_zero ? '0 :
                                                     hit     ? wd3 : mem[addr];
        assign rd_busy[i] = ~is_zero & ~hit & pending[addr];
`else
        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = is_zero ? '0 : mem[addr];
        assign rd_busy[i] = ~is_zero & pending[addr];
`endif
    end

    assign a0 = mem[DBG_IDX];

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb (vector table, hand sequences, random model)

module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [9:0]  ad_rd;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we3;
    logic [4:0]  ad3;
    logic [31:0] wd3;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [31:0] a0;

    regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .ad_rd     (ad_rd),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we3       (we3),
        .ad3       (ad3),
        .wd3       (wd3),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .a0        (a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  ad3;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  ebusy;
        logic        erdy;
        logic [31:0] ea0;
    } vec_t;

    typedef struct {
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  ebusy;
        logic        erdy;
        logic [31:0] ea0;
    } exp_t;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    logic [31:0] m_mem [32];
    logic [31:0] m_pend;

    function automatic logic [31:0] sel(input logic [31:0] with_byp, input logic [31:0] without);
        return BYP ? with_byp : without;
    endfunction

    function automatic vec_t mk(input logic we, input logic [4:0] a, input logic [31:0] wd,
                                input logic iv, input logic [4:0] ird,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] ebusy, input logic erdy, input logic [31:0] ea0);
        vec_t v;
        v.we = we; v.ad3 = a; v.wd = wd; v.iv = iv; v.ird = ird; v.r0 = r0; v.r1 = r1;
        v.e0 = e0; v.e1 = e1; v.ebusy = ebusy; v.erdy = erdy; v.ea0 = ea0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] r0, input logic [4:0] r1);
        we3 = we; ad3 = a; wd3 = wd; iss_valid = iv; iss_rd = ird; ad_rd = {r1, r0};
    endtask

    // Pops the oldest expectation and compares it to what the DUT shows now.
    task automatic compare_head(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, " queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, " rd_data0"}, rd_data[31:0], e.e0);
            check({tag, " rd_data1"}, rd_data[63:32], e.e1);
            check({tag, " rd_busy"}, {30'd0, rd_busy}, {30'd0, e.ebusy});
            check({tag, " iss_ready"}, {31'd0, iss_ready}, {31'd0, e.erdy});
            check({tag, " a0"}, a0, e.ea0);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        exp_t e;
        logic [4:0] pool [7];
        pool[0] = 5'd0; pool[1] = 5'd1; pool[2] = 5'd3; pool[3] = 5'd5;
        pool[4] = 5'd7; pool[5] = 5'd10; pool[6] = 5'd31;

        //        we  ad3    wd3           iv ird    r0     r1     e0                                e1                     busy                        rdy   a0
        vecs.push_back(mk(1, 5'd0, 32'hDEADBEEF, 1, 5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 1, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 1, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd5, 5'd5, 5'd0, 0, 0, 2'b00, 1, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd5, 5'd5, 5'd5, 0, 0, 2'b11, 0, 0));
        vecs.push_back(mk(1, 5'd5, 32'h1234,     0, 5'd5, 5'd5, 5'd0, sel(32'h1234, 0), 0,
                          {1'b0, ~BYP}, 1, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd5, 5'd5, 5'd5, 32'h1234, 32'h1234, 2'b00, 1, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd7, 5'd7, 5'd0, 0, 0, 2'b00, 1, 0));
        vecs.push_back(mk(1, 5'd7, 32'h55,       1, 5'd7, 5'd7, 5'd5, sel(32'h55, 0), 32'h1234,
                          {1'b0, ~BYP}, 1, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd7, 5'd7, 5'd0, 32'h55, 0, 2'b01, 0, 0));
        vecs.push_back(mk(1, 5'd10, 32'hCAFE0001, 0, 5'd0, 5'd10, 5'd7, sel(32'hCAFE0001, 0), 32'h55,
                          2'b10, 1, 0));
        vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd0, 5'd10, 5'd3, 32'hCAFE0001, 0, 2'b00, 1, 32'hCAFE0001));
        vecs.push_back(mk(1, 5'd7, 32'h77,       1, 5'd31, 5'd31, 5'd7, 0, sel(32'h77, 32'h55),
                          {~BYP, 1'b0}, 1, 32'hCAFE0001));
        vecs.push_back(mk(1, 5'd31, 32'hFFFFFFFF, 1, 5'd31, 5'd31, 5'd7, sel(32'hFFFFFFFF, 0), 32'h77,
                          {1'b0, ~BYP}, 1, 32'hCAFE0001));
        vecs.push_back(mk(0, 5'd0, 32'h0,        1, 5'd31, 5'd31, 5'd0, 32'hFFFFFFFF, 0, 2'b01, 0, 32'hCAFE0001));
        vecs.push_back(mk(1, 5'd31, 32'h1,       0, 5'd0, 5'd1, 5'd0, 0, 0, 2'b00, 1, 32'hCAFE0001));
        vecs.push_back(mk(0, 5'd0, 32'h0,        0, 5'd31, 5'd31, 5'd31, 32'h1, 32'h1, 2'b00, 1, 32'hCAFE0001));

        // Reset with prior writes and a claim present
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick; tick;
        rst = 1'b0;
        drive(1, 5'd4, 32'h44, 1, 5'd4, 5'd0, 5'd0);
        tick;
        drive(1, 5'd10, 32'hA, 0, 5'd4, 5'd4, 5'd10);
        tick;
        drive(0, 0, 0, 1, 5'd4, 5'd4, 5'd10);
        #1;
        check("pre_reset a0", a0, 32'hA);
        check("pre_reset busy4", {31'd0, rd_busy[0]}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("reset rd_data", rd_data[31:0] | rd_data[63:32], 32'd0);
        check("reset rd_busy", {30'd0, rd_busy}, 32'd0);
        check("reset a0", a0, 32'd0);
        check("reset iss_ready", {31'd0, iss_ready}, 32'd1);
        tick;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick;

        // Table: expectations queued at drive time, compared mid-cycle
        foreach (vecs[k]) begin
            drive(vecs[k].we, vecs[k].ad3, vecs[k].wd, vecs[k].iv, vecs[k].ird, vecs[k].r0, vecs[k].r1);
            e.e0 = vecs[k].e0; e.e1 = vecs[k].e1; e.ebusy = vecs[k].ebusy;
            e.erdy = vecs[k].erdy; e.ea0 = vecs[k].ea0;
            sb_q.push_back(e);
            @(negedge clk);
            compare_head($sformatf("vec%0d", k));
            tick;
        end

        // Claim x3, then async reset mid-cycle with no clock edge
        drive(1, 5'd3, 32'h33, 0, 5'd0, 5'd3, 5'd0);
        tick;
        drive(0, 0, 0, 1, 5'd3, 5'd3, 5'd3);
        tick;
        drive(0, 0, 0, 0, 5'd3, 5'd3, 5'd3);
        #1;
        check("x3 busy", {30'd0, rd_busy}, 32'd3);
        check("x3 data", rd_data[31:0], 32'h33);
        #2;
        rst = 1'b1;
        #1;
        check("async x3 busy", {30'd0, rd_busy}, 32'd0);
        check("async x3 data", rd_data[31:0], 32'd0);
        check("async iss_ready", {31'd0, iss_ready}, 32'd1);
        tick;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick;

        // Random traffic against a reference model of stored data and pending bits
        for (int r = 0; r < 32; r++) m_mem[r] = '0;
        m_pend = '0;
        for (int n = 0; n < 150; n++) begin
            logic        we, iv, rdy, hit0, hit1;
            logic [4:0]  a, ird, r0, r1;
            logic [31:0] wd;
            we  = 1'($urandom_range(0, 1));
            a   = pool[$urandom_range(0, 6)];
            wd  = $urandom;
            iv  = 1'($urandom_range(0, 1));
            ird = pool[$urandom_range(0, 6)];
            r0  = pool[$urandom_range(0, 6)];
            r1  = pool[$urandom_range(0, 6)];
            drive(we, a, wd, iv, ird, r0, r1);
            rdy  = ~m_pend[ird] | (ird == 0) | (we & (a == ird));
            hit0 = BYP & we & (a != 0) & (a == r0);
            hit1 = BYP & we & (a != 0) & (a == r1);
            e.e0 = (r0 == 0) ? 32'd0 : hit0 ? wd : m_mem[r0];
            e.e1 = (r1 == 0) ? 32'd0 : hit1 ? wd : m_mem[r1];
            e.ebusy = {(r1 != 0) & ~hit1 & m_pend[r1], (r0 != 0) & ~hit0 & m_pend[r0]};
            e.erdy = rdy;
            e.ea0 = m_mem[10];
            sb_q.push_back(e);
            @(negedge clk);
            compare_head($sformatf("rnd%0d", n));
            if (we && a != 0) begin
                m_mem[a]  = wd;
                m_pend[a] = 1'b0;
            end
            if (iv && rdy && ird != 0) m_pend[ird] = 1'b1;
            tick;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Next-generation integer register file for the pipelined core. It has a parametrised number of asynchronous read ports, one synchronous write port, x0 hardwired to zero, and asynchronous reset of all state. It adds a per-register pending-write scoreboard: decode claims a destination at issue, and writeback releases it. Hazard/stall logic consumes the resulting busy flags. It keeps a debug tap of a0 for the testbench/top level.

Parameters:
ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH
DATA_WIDTH, 32, register data width
NUM_READ, 2, number of read ports (>=1)
DBG_REG, 10, index mirrored on a0 output (ABI a0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
ad_rd  input  NUM_READ*ADDRESS_WIDTH  packed read addresses, port i at [i*AW +: AW]
rd_data  output  NUM_READ*DATA_WIDTH  packed read data, port i at [i*DW +: DW]
rd_busy  output  NUM_READ  port i source register has a pending write
we3  input  1  write enable
ad3  input  ADDRESS_WIDTH  write address
wd3  input  DATA_WIDTH  write data
iss_valid  input  1  decode requests to claim iss_rd
iss_rd  input  ADDRESS_WIDTH  destination being claimed
iss_ready  output  1  claim can be accepted this cycle
a0  output  DATA_WIDTH  current contents of register DBG_REG

Behaviour:
- Reset (async assert, sync-safe release): all registers = 0, all pending bits = 0. Outputs: rd_data = 0, rd_busy = 0, a0 = 0, iss_ready = 1.
- Reads are combinational, with zero latency from ad_rd. Address 0 always returns 0, and rd_busy for that port is always 0.
- Write: on posedge clk with we3=1 and ad3!=0, reg[ad3] <= wd3. Writes to x0 are discarded.
- Scoreboard pending[r], r=1..depth-1. pending[0] is constant 0.
- Claim accepted when iss_valid & iss_ready & iss_rd!=0. On the next edge, pending[iss_rd] <= 1. A claim of x0 is accepted and has no effect.
- Release: on an edge where we3=1 and ad3!=0, pending[ad3] <= 0. A write to a non-pending register (e.g. debug/CSR path) is legal; the release is a no-op.
- Simultaneous claim and release of the same register: set wins, so pending stays 1 (the new producer owns it).
- iss_ready = ~pending[iss_rd] | (iss_rd==0) | (we3 & ad3==iss_rd). A WAW on a still-pending register stalls, unless that register is being released in the same cycle.
- iss_ready is combinational from the current state and inputs. Claims are never queued; the requester holds iss_valid/iss_rd until iss_ready.
- rd_busy[i] = pending[ad_rd port i], subject to the bypass rule below.
- a0 = reg[DBG_REG], with no bypass; it reflects only stored state.
- Reset asserted mid-operation clears registers and pending immediately. Claims and writes in that cycle are lost.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding. If we3=1, ad3!=0 and ad3 equals read port i's address, then rd_data[i] = wd3 and rd_busy[i] = 0 in the same cycle. iss_ready behaves as specified above in both builds.
- Undefined: rd_data shows only stored values, and rd_busy reflects the pending bit before the edge. The written value and the cleared busy become visible one cycle after the write.

Decomposition:
- Package regfile_pkg:
  - ADDRESS_WIDTH/DATA_WIDTH defaults
  - typedefs reg_addr_t, reg_data_t
  - constants REG_ZERO=0, REG_A0=10
- One sub-module, regfile_scoreboard: the pending bit-vector, set/clear priority, and iss_ready generation.
- The data array, read muxing and bypass stay in regfile_sb.

Test Plan:
1. Reset with prior writes present → every port reads 0, rd_busy=0, a0=0, iss_ready=1.
2. we3=1, ad3=0, wd3=32'hDEADBEEF, then read x0 on all ports → 0. Claim of iss_rd=0 → iss_ready=1, rd_busy stays 0.
3. Claim x5 (iss_valid=1), then read x5 → rd_busy=1. Claim x5 again → iss_ready=0. Write x5=32'h1234 → the next cycle has rd_busy=0, rd_data=32'h1234, and iss_ready=1.
4. Same cycle: claim x7 with we3 ad3=7 wd3=32'h55 while x7 is pending → iss_ready=1. After the edge, x7=32'h55 and pending[7]=1.
5. Write x10=32'hCAFE0001 → a0=32'hCAFE0001 one cycle later. The same-cycle read of x10 gives the new value with REGFILE_BYPASS_EN and the old value without it.
6. Claim x3, then assert rst mid-cycle (async) → pending cleared and x3=0 immediately, with no clock edge required.
